// File: rtl/mult_acc_pkg.sv
// Shared types and width helper for the product accumulator.
package mult_acc_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } mult_acc_state_t;

  // Default accumulator width: the 2N-bit product plus two guard bits.
  function automatic int unsigned acc_width(input int unsigned n);
    return 2 * n + 2;
  endfunction

endpackage

// File: rtl/beat_counter.sv
// Modulo-COUNT beat counter with synchronous clear; flags the final beat of a sum.
module beat_counter #(
  parameter int unsigned COUNT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_last
);

  localparam int unsigned CNT_W = $clog2(COUNT + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(COUNT - 1);

  logic [CNT_W-1:0] r_cnt;

  assign o_last = (r_cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= o_last ? '0 : r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mult_accumulator.sv
// Sums COUNT unsigned products and hands the result out on a valid/ready port.
// Define MULT_ACC_SATURATE_EN to clamp on overflow instead of wrapping.
module mult_accumulator
  import mult_acc_pkg::*;
#(
  parameter int unsigned N     = 5,
  parameter int unsigned COUNT = 4,
  parameter int unsigned ACC_W = acc_width(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2*N-1:0]   product,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             overflow
);

  mult_acc_state_t  r_state;
  logic [ACC_W-1:0] r_acc;
  logic             r_ovf;

  logic             w_accept;
  logic             w_drain;
  logic             w_last;
  logic             w_carry;
  logic [ACC_W:0]   w_sum;

  assign in_ready  = (r_state == ACCUM);
  assign out_valid = (r_state == DONE);
  assign acc_out   = r_acc;
  assign overflow  = r_ovf;

  // clear outranks both handshakes, so a beat offered alongside it is dropped.
  assign w_accept = in_valid && in_ready && !clear;
  assign w_drain  = out_valid && out_ready && !clear;

  assign w_sum   = {1'b0, r_acc} + {{(ACC_W + 1 - 2 * N){1'b0}}, product};
  assign w_carry = w_sum[ACC_W];

  beat_counter #(
    .COUNT(COUNT)
  ) u_beat_counter (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_accept),
    .i_clr (clear || w_drain),
    .o_last(w_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ACCUM;
      r_acc   <= '0;
      r_ovf   <= 1'b0;
    end else if (clear || w_drain) begin
      r_state <= ACCUM;
      r_acc   <= '0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
`ifdef MULT_ACC_SATURATE_EN
      r_acc <= w_carry ? '1 : w_sum[ACC_W-1:0];
`else
      r_acc <= w_sum[ACC_W-1:0];
`endif
      if (w_carry) begin
        r_ovf <= 1'b1;
      end
      if (w_last) begin
        r_state <= DONE;
      end
    end
  end

endmodule
